imem_arb: RTL and testbench

IMEM_ARB -- requirements
Module: imem_arb

---
 rtl/imem_arb.sv | 158 +++++++++++++++
 tb/tb_imem_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arb.sv
// imem_arb: arbitrates instruction fetch and loader traffic onto one
// single-port instruction memory with a 1-cycle read latency.
//
// Grants are decided combinationally in the request cycle. The granted
// requester sees its response exactly one cycle later.
//
// The loader normally has strict priority over fetch. If the optional
// macro IMEM_ARB_STARVE_EN is defined, a starvation guard is added: after
// STARVE_MAX consecutive cycles in which the loader beats a requesting
// fetch, fetch wins one cycle.
//
// Handshake: a request is accepted in the cycle its gnt is high. Its
// rvalid pulses for exactly the following cycle. rdata is zero whenever
// rvalid is low.
module imem_arb #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic              f_err,
    output logic [31:0]       f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // NOP (addi x0,x0,0) returned for a faulting fetch.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        F_RESP = 2'd1,
        L_RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic f_bad;      // fetch address is misaligned or beyond the memory
    logic fetch_win;  // starvation guard forces fetch this cycle
    logic f_err_q;    // fetch granted last cycle was a faulting one
    logic l_we_q;     // loader granted last cycle was a write

    assign f_bad = (f_addr[1:0] != 2'b00) ||
                   ((f_addr >> (ADDR_W + 2)) != 32'd0);

`ifdef IMEM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign fetch_win = (starve_cnt == CNT_W'(STARVE_MAX));

    // Count consecutive cycles in which the loader beat a waiting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!f_req || f_gnt) begin
            starve_cnt <= '0;
        end else if (l_gnt) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign fetch_win = 1'b0;
`endif

    // Pick at most one requester. Nothing is granted while reset is held.
    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (rst_n) begin
            if (l_req && !(f_req && fetch_win)) begin
                l_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
        end
    end

    // Drive the memory port for the granted access. A faulting fetch never
    // touches memory.
    always_comb begin
        mem_en    = l_gnt || (f_gnt && !f_bad);
        mem_we    = l_gnt && l_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (l_gnt) begin
            mem_addr = l_addr;
            if (l_we) begin
                mem_wdata = l_wdata;
            end
        end else if (f_gnt) begin
            mem_addr = f_addr[ADDR_W+1:2];
        end
    end

    // State register, plus the attributes of the response now in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            f_err_q <= 1'b0;
            l_we_q  <= 1'b0;
        end else begin
            state   <= next_state;
            f_err_q <= f_gnt && f_bad;
            l_we_q  <= l_gnt && l_we;
        end
    end

    // The response owner for next cycle is whoever is granted this cycle.
    always_comb begin
        next_state = IDLE;
        if (f_gnt) begin
            next_state = F_RESP;
        end else if (l_gnt) begin
            next_state = L_RESP;
        end
    end

    // Present the response for the access granted one cycle ago.
    always_comb begin
        f_rvalid = 1'b0;
        f_err    = 1'b0;
        f_rdata  = 32'd0;
        l_rvalid = 1'b0;
        l_rdata  = 32'd0;
        case (state)
            F_RESP: begin
                f_rvalid = 1'b1;
                f_err    = f_err_q;
                f_rdata  = f_err_q ? NOP_INSN : mem_rdata;
            end
            L_RESP: begin
                l_rvalid = 1'b1;
                l_rdata  = l_we_q ? 32'd0 : mem_rdata;
            end
            default: begin
                f_rvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_arb.sv
// tb_imem_arb: randomized and directed checks of imem_arb against a
// high-level reference model. Build with +define+IMEM_ARB_STARVE_EN to
// check the starvation guard.
module tb_imem_arb;

  localparam int ADDR_W     = 10;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  // Expected response: {owner[1:0], err, data[31:0]}.
  // owner: 0 = none, 1 = fetch, 2 = loader.
  localparam int RW = 35;

  logic              clk;
  logic              rst_n;
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic              f_err;
  logic [31:0]       f_rdata;
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [31:0]       l_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ref_mem [DEPTH];
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_e;

  int checks;
  int errors;
  int denied;
  int fgnt_seen;

  imem_arb #(
    .ADDR_W(ADDR_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .f_req(f_req),
    .f_addr(f_addr),
    .f_gnt(f_gnt),
    .f_rvalid(f_rvalid),
    .f_err(f_err),
    .f_rdata(f_rdata),
    .l_req(l_req),
    .l_we(l_we),
    .l_addr(l_addr),
    .l_wdata(l_wdata),
    .l_gnt(l_gnt),
    .l_rvalid(l_rvalid),
    .l_rdata(l_rdata),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // single-port memory, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one request cycle, with grant checks and expected-response push
  task automatic do_cycle(input logic fr, input logic [31:0] fa, input logic lr,
                          input logic lw, input logic [ADDR_W-1:0] la, input logic [31:0] ld);
    logic bad;
    logic win_f;
    logic win_l;
    logic exp_en;
    logic [ADDR_W-1:0] word;
    @(negedge clk);
    f_req   = fr;
    f_addr  = fa;
    l_req   = lr;
    l_we    = lw;
    l_addr  = la;
    l_wdata = ld;
    #1;
    bad  = (fa[1:0] != 2'b00) || (fa >= 32'(DEPTH * 4));
    word = fa[ADDR_W+1:2];
`ifdef IMEM_ARB_STARVE_EN
    win_f = fr && (!lr || denied == STARVE_MAX);
`else
    win_f = fr && !lr;
`endif
    win_l  = lr && !win_f;
    exp_en = win_l || (win_f && !bad);
    chk("f_gnt", 32'(f_gnt), 32'(win_f));
    chk("l_gnt", 32'(l_gnt), 32'(win_l));
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    chk("mem_we", 32'(mem_we), 32'(win_l && lw));
    if (exp_en) chk("mem_addr", 32'(mem_addr), win_l ? 32'(la) : 32'(word));
    if (win_l && lw) chk("mem_wdata", mem_wdata, ld);
    if (f_gnt) fgnt_seen++;
    if (win_f) begin
      exp_q.push_back({2'd1, bad, bad ? 32'h0000_0013 : ref_mem[word]});
    end else if (win_l) begin
      exp_q.push_back({2'd2, 1'b0, lw ? 32'd0 : ref_mem[la]});
      if (lw) ref_mem[la] = ld;
    end else begin
      exp_q.push_back('0);
    end
    if (!fr || win_f) denied = 0;
    else if (lr) denied++;
  endtask

  task automatic idle();
    do_cycle(1'b0, 32'd0, 1'b0, 1'b0, '0, 32'd0);
  endtask

  // monitor: one expected response (or none) per cycle
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) mon_e = exp_q.pop_front();
    else mon_e = '0;
    chk("f_rvalid", 32'(f_rvalid), 32'(mon_e[34:33] == 2'd1));
    chk("l_rvalid", 32'(l_rvalid), 32'(mon_e[34:33] == 2'd2));
    chk("f_err", 32'(f_err), 32'(mon_e[34:33] == 2'd1 && mon_e[32]));
    chk("f_rdata", f_rdata, (mon_e[34:33] == 2'd1) ? mon_e[31:0] : 32'd0);
    chk("l_rdata", l_rdata, (mon_e[34:33] == 2'd2) ? mon_e[31:0] : 32'd0);
  end

  initial begin
    logic [31:0] fa;
    int r;
    checks    = 0;
    errors    = 0;
    denied    = 0;
    fgnt_seen = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    // requests held active during reset must not be granted
    rst_n   = 1'b0;
    f_req   = 1'b1;
    f_addr  = 32'h8;
    l_req   = 1'b1;
    l_we    = 1'b1;
    l_addr  = 5;
    l_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("rst_f_gnt", 32'(f_gnt), 32'd0);
    chk("rst_l_gnt", 32'(l_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    f_req = 1'b0;
    l_req = 1'b0;
    l_we  = 1'b0;

    // fetch only, then faulting fetches
    do_cycle(1'b1, 32'h8, 1'b0, 1'b0, '0, 32'd0);
    do_cycle(1'b1, 32'h6, 1'b0, 1'b0, '0, 32'd0);
    do_cycle(1'b1, 32'h1000, 1'b0, 1'b0, '0, 32'd0);
    // loader write then fetch of the same word
    do_cycle(1'b0, 32'd0, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
    do_cycle(1'b1, 32'h14, 1'b0, 1'b0, '0, 32'd0);
    // loader read
    do_cycle(1'b0, 32'd0, 1'b1, 1'b0, 10'd5, 32'd0);
    idle();

    // sustained contention
    fgnt_seen = 0;
    repeat (10) do_cycle(1'b1, 32'h4, 1'b1, 1'b0, 10'd3, 32'd0);
`ifdef IMEM_ARB_STARVE_EN
    chk("contention_fetch_grants", 32'(fgnt_seen), 32'd2);
`else
    chk("contention_fetch_grants", 32'(fgnt_seen), 32'd0);
`endif
    idle();

    // reset while a fetch response is pending
    do_cycle(1'b1, 32'h8, 1'b0, 1'b0, '0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_f_gnt", 32'(f_gnt), 32'd0);
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_f_rvalid", 32'(f_rvalid), 32'd0);
    exp_q.delete();
    denied = 0;
    f_req  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(1'b1, 32'h0, 1'b0, 1'b0, '0, 32'd0);
    idle();

    // randomized traffic
    repeat (400) begin
      r = $urandom_range(0, 9);
      if (r < 7) fa = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r < 9) fa = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else fa = $urandom | 32'h0000_1000;
      do_cycle(1'($urandom_range(0, 1)), fa, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom);
    end
    repeat (3) idle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
